lfsr_reconfig_gen: RTL and testbench

- Parametrised successor to the fixed/configurable LFSR top.
- Single WIDTH-bit LFSR with runtime-selectable Fibonacci or Galois mode.
- Taps, seed and mode load through a valid/ready configuration handshake.
- Adds all-zero lockup recovery and measures the sequence period; feeds pattern-generation and BIST logic.

---
 rtl/lfsr_reconfig_gen.sv | 75 +++++++
 tb/tb_lfsr_reconfig_gen.sv | 113 +++++++++++
 2 files changed

// File: rtl/lfsr_reconfig_gen.sv
// lfsr_reconfig_gen: runtime-reconfigurable Fibonacci/Galois LFSR with lockup recovery and period measurement
module lfsr_reconfig_gen #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] DEFAULT_TAPS = 8'hB8,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             use_config_lfsr,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_taps,
  input  logic [WIDTH-1:0] cfg_seed,
  input  logic             cfg_mode,
  output logic [WIDTH-1:0] lfsr_out,
  output logic             period_done,
  output logic [WIDTH-1:0] period_len,
  output logic             lockup
);
  typedef enum logic {RUN, LOAD} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] taps_reg, seed_reg, step_cnt;
  logic mode_reg;
  logic [WIDTH-1:0] eff_taps, next_s, seed_sub, cnt_inc;
  logic eff_mode, accept;
  always_comb begin
    cfg_ready = state == RUN;
    state_nx = (state == RUN && cfg_valid) ? LOAD : RUN;
    accept = cfg_ready && cfg_valid;
    eff_taps = use_config_lfsr ? taps_reg : DEFAULT_TAPS;
    eff_mode = use_config_lfsr && mode_reg;
    next_s = eff_mode ? ({lfsr_out[WIDTH-2:0], 1'b0} ^ ({WIDTH{lfsr_out[WIDTH-1]}} & eff_taps))
                      : {lfsr_out[WIDTH-2:0], ^(lfsr_out & eff_taps)};
    seed_sub = (cfg_seed == '0) ? DEFAULT_SEED : cfg_seed;
    cnt_inc = (&step_cnt) ? step_cnt : step_cnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      lfsr_out <= DEFAULT_SEED;
      taps_reg <= DEFAULT_TAPS;
      seed_reg <= DEFAULT_SEED;
      mode_reg <= 1'b0;
      step_cnt <= '0;
      period_len <= '0;
      period_done <= 1'b0;
      lockup <= 1'b0;
    end else begin
      state <= state_nx;
      period_done <= 1'b0;
      lockup <= 1'b0;
      if (accept) begin
        taps_reg <= cfg_taps;
        mode_reg <= cfg_mode;
        seed_reg <= seed_sub;
        lfsr_out <= seed_sub;
        step_cnt <= '0;
      end else if (state == RUN && lfsr_out == '0) begin
        lfsr_out <= seed_reg;
        step_cnt <= '0;
        lockup <= 1'b1;
      end else if (state == RUN && enable) begin
        lfsr_out <= next_s;
        if (next_s == seed_reg) begin
          period_done <= 1'b1;
          period_len <= cnt_inc;
          step_cnt <= '0;
        end else begin
          step_cnt <= cnt_inc;
        end
      end
    end
  end
endmodule

// File: tb/tb_lfsr_reconfig_gen.sv
// tb_lfsr_reconfig_gen: randomized scoreboard bench against an integer reference model (WIDTH=4)
module tb_lfsr_reconfig_gen;
  logic clk = 0, reset = 0, enable = 0, use_config_lfsr = 0, cfg_valid = 0, cfg_mode = 0;
  logic [3:0] cfg_taps = 0, cfg_seed = 0;
  logic cfg_ready, period_done, lockup;
  logic [3:0] lfsr_out, period_len;
  int tests = 0, fails = 0;

  lfsr_reconfig_gen #(.WIDTH(4), .DEFAULT_TAPS(4'b1001), .DEFAULT_SEED(4'b0001)) dut (
    .clk(clk), .reset(reset), .enable(enable), .use_config_lfsr(use_config_lfsr),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_taps(cfg_taps), .cfg_seed(cfg_seed),
    .cfg_mode(cfg_mode), .lfsr_out(lfsr_out), .period_done(period_done),
    .period_len(period_len), .lockup(lockup));

  always #5 clk = ~clk;

  typedef struct {int s; int pd; int len; int lk; int rdy;} exp_t;
  exp_t q[$];

  int m_s, m_taps, m_seed, m_mode, m_cnt, m_len, m_pd, m_lk, m_load;

  function automatic int nxt(int s, int t, int gal);
    if (gal != 0) return ((s * 2) ^ ((s >= 8) ? t : 0)) % 16;
    return (s * 2 + ($countones(s & t) % 2)) % 16;
  endfunction

  task automatic model_edge();
    exp_t e;
    if (reset) begin
      m_s = 1; m_taps = 9; m_seed = 1; m_mode = 0; m_cnt = 0; m_len = 0;
      m_pd = 0; m_lk = 0; m_load = 0;
    end else begin
      m_pd = 0; m_lk = 0;
      if (m_load != 0) m_load = 0;
      else if (cfg_valid) begin
        m_taps = cfg_taps; m_mode = cfg_mode;
        m_seed = (cfg_seed == 0) ? 1 : int'(cfg_seed);
        m_s = m_seed; m_cnt = 0; m_load = 1;
      end else if (m_s == 0) begin
        m_s = m_seed; m_cnt = 0; m_lk = 1;
      end else if (enable) begin
        int c;
        m_s = nxt(m_s, use_config_lfsr ? m_taps : 9, use_config_lfsr ? m_mode : 0);
        c = (m_cnt == 15) ? 15 : m_cnt + 1;
        if (m_s == m_seed) begin m_pd = 1; m_len = c; m_cnt = 0; end
        else m_cnt = c;
      end
    end
    e.s = m_s; e.pd = m_pd; e.len = m_len; e.lk = m_lk; e.rdy = (m_load == 0);
    q.push_back(e);
  endtask

  task automatic step(input logic r, input logic en, input logic use_c, input logic cv,
                      input logic [3:0] t, input logic [3:0] sd, input logic md);
    reset = r; enable = en; use_config_lfsr = use_c; cfg_valid = cv;
    cfg_taps = t; cfg_seed = sd; cfg_mode = md;
    model_edge();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("lfsr_out", int'(lfsr_out), e.s);
      chk("period_done", int'(period_done), e.pd);
      chk("period_len", int'(period_len), e.len);
      chk("lockup", int'(lockup), e.lk);
      chk("cfg_ready", int'(cfg_ready), e.rdy);
    end
  end

  initial begin
    @(negedge clk);
    repeat (2) step(1, 0, 0, 0, 0, 0, 0);
    // default Fibonacci sequence, full period 15
    repeat (20) step(0, 1, 0, 0, 0, 0, 0);
    // Galois taps 0011 seed 0001
    step(0, 1, 1, 1, 4'b0011, 4'b0001, 1);
    repeat (20) step(0, 1, 1, 0, 0, 0, 0);
    // zero seed substitutes default seed
    step(0, 0, 1, 1, 4'b1001, 4'b0000, 0);
    repeat (3) step(0, 0, 1, 0, 0, 0, 0);
    // zero taps drive into lockup recovery
    step(0, 1, 1, 1, 4'b0000, 4'b0001, 0);
    repeat (8) step(0, 1, 1, 0, 0, 0, 0);
    // continuous cfg_valid: accepted every other cycle, no stepping
    repeat (6) step(0, 1, 1, 1, 4'b0011, 4'b0101, 1);
    // reset during LOAD and mid-sequence
    step(0, 1, 1, 1, 4'b0011, 4'b0110, 1);
    step(1, 1, 1, 0, 0, 0, 0);
    repeat (5) step(0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
           $urandom_range(0, 19) == 0, 4'($urandom), 4'($urandom), 1'($urandom));
    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
